// File: rtl/ps2_key_event_fifo.sv
// ps2_key_event_fifo
//
// Turns the PS/2 receiver's 16-bit code bus into typed key events and queues
// them for the application layer.
//
// Each new, recognised code becomes one 11-bit event {repeat, make, ext, scan}.
// The receiver's idle and status patterns are dropped. Events are held in a
// DEPTH-entry circular FIFO and handed out over a valid/ready handshake.
//
// Ports
//   clk        in   system clock, shared with the receiver
//   rst_n      in   synchronous active-low reset
//   code       in   receiver code bus {hi, lo}
//   ev_ready   in   consumer accepts the head event
//   ovf_clr    in   pulse that clears the sticky overflow flag
//   ev_valid   out  head event valid (FIFO not empty)
//   ev_data    out  head event {repeat, make, ext, scan[7:0]}
//   count      out  FIFO occupancy, 0..DEPTH
//   overflow   out  sticky; set when an event is dropped on a full FIFO
//   last_make  out  scan code of the most recent make event

module ps2_key_event_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   code,
    input  logic          ev_ready,
    input  logic          ovf_clr,
    output logic          ev_valid,
    output logic [10:0]   ev_data,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    last_make
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [15:0]   code_q,      code_d;
    logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [AW:0]   count_q,     count_d;
    logic [10:0]   ev_data_q,   ev_data_d;
    logic          overflow_q,  overflow_d;
    logic [7:0]    last_make_q, last_make_d;
    logic          lm_ext_q,    lm_ext_d;
    logic          lm_valid_q,  lm_valid_d;
    logic [10:0]   mem_q [DEPTH];
    logic [10:0]   mem_d [DEPTH];

    logic [7:0]    hi;
    logic [7:0]    lo;
    logic          is_valid;
    logic          is_make;
    logic          is_ext;
    logic          det;
    logic          rpt;
    logic [10:0]   ev_word;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;

    // Classification of the live bus value
    always_comb begin
        hi       = code[15:8];
        lo       = code[7:0];
        is_valid = 1'b0;
        is_make  = 1'b0;
        is_ext   = 1'b0;
        // lo = FF marks a receiver status word regardless of hi
        if (lo != 8'hFF) begin
            if (hi == 8'h00 || hi == 8'h11) begin
                is_valid = 1'b1;
                is_make  = 1'b1;
            end else if (hi == 8'hE0 && lo != 8'hF0) begin
                is_valid = 1'b1;
                is_make  = 1'b1;
                is_ext   = 1'b1;
            end else if (hi == 8'hF0) begin
                is_valid = 1'b1;
            end
        end
    end

    // Event detection, repeat flag and FIFO control
    always_comb begin
        det     = is_valid && (code != code_q);
        rpt     = is_make && lm_valid_q && (lm_ext_q == is_ext) && (last_make_q == lo);
        ev_word = {rpt, is_make, is_ext, lo};

        empty = (count_q == '0);
        full  = (count_q == DEPTH_C);
        pop   = !empty && ev_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle
        push  = det && (!full || pop);
        drop  = det && full && !pop;

        code_d   = code;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = ev_word;
        end

        // Head register only moves on a pop or on empty -> non-empty. When the
        // new head is the entry being written this cycle, bypass storage.
        ev_data_d = ev_data_q;
        if (pop || (push && empty)) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                ev_data_d = ev_word;
            end else begin
                ev_data_d = mem_q[rd_ptr_d];
            end
        end

        // Set has priority over clear
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        last_make_d = last_make_q;
        lm_ext_d    = lm_ext_q;
        lm_valid_d  = lm_valid_q;
        if (det) begin
            if (is_make) begin
                last_make_d = lo;
                lm_ext_d    = is_ext;
                lm_valid_d  = 1'b1;
            end else begin
                lm_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q      <= 16'hFFFF;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ev_data_q   <= 11'h000;
            overflow_q  <= 1'b0;
            last_make_q <= 8'h00;
            lm_ext_q    <= 1'b0;
            lm_valid_q  <= 1'b0;
        end else begin
            code_q      <= code_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ev_data_q   <= ev_data_d;
            overflow_q  <= overflow_d;
            last_make_q <= last_make_d;
            lm_ext_q    <= lm_ext_d;
            lm_valid_q  <= lm_valid_d;
        end
    end

    // Storage is not reset; reset empties the FIFO through the pointers/count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ev_valid  = (count_q != '0);
    assign ev_data   = ev_data_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign last_make = last_make_q;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Scoreboard bench for ps2_key_event_fifo. Stimulus pushes hand-computed
// expected events into a queue; a negedge monitor pops and compares each
// event the DUT hands over.

module tb_ps2_key_event_fifo;

    logic        clk;
    logic        rst_n;
    logic [15:0] code;
    logic        ev_ready;
    logic        ovf_clr;
    logic        ev_valid;
    logic [10:0] ev_data;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  last_make;

    int total;
    int bad;
    logic [10:0] sb [$];

    ps2_key_event_fifo #(.DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code      (code),
        .ev_ready  (ev_ready),
        .ovf_clr   (ovf_clr),
        .ev_valid  (ev_valid),
        .ev_data   (ev_data),
        .count     (count),
        .overflow  (overflow),
        .last_make (last_make)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got %0h expected none", ev_data);
            end else begin
                logic [10:0] e;
                e = sb.pop_front();
                if (ev_data !== e) begin
                    bad++;
                    $display("FAIL event: got %0h expected %0h", ev_data, e);
                end
            end
        end
    end

    task automatic cyc(input logic [15:0] c, input int n);
        code = c;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ev_valid"},  {31'd0, ev_valid},  32'd0);
        check({tag, "_ev_data"},   {21'd0, ev_data},   32'h000);
        check({tag, "_count"},     {28'd0, count},     32'd0);
        check({tag, "_overflow"},  {31'd0, overflow},  32'd0);
        check({tag, "_last_make"}, {24'd0, last_make}, 32'h00);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        cyc(16'hFFFF, 2);
        sb.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        code     = 16'hFFFF;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;

        // Reset values and single make
        do_reset();
        check_reset_outputs("reset");
        ev_ready = 1'b1;
        sb.push_back(11'h21C);
        cyc(16'h001C, 3);
        cyc(16'h1FFF, 3);
        check("make_valid_low", {31'd0, ev_valid}, 32'd0);
        check("make_last_make", {24'd0, last_make}, 32'h1C);
        check("make_sb_empty", sb.size(), 32'd0);

        // Typematic repeat, break, then fresh make
        do_reset();
        ev_ready = 1'b1;
        sb.push_back(11'h21C);
        sb.push_back(11'h61C);
        sb.push_back(11'h01C);
        sb.push_back(11'h21C);
        cyc(16'h001C, 1);
        cyc(16'h3FFF, 1);
        cyc(16'h001C, 1);
        cyc(16'h5555, 1);
        cyc(16'hF01C, 1);
        cyc(16'h001C, 1);
        cyc(16'h1FFF, 3);
        check("repeat_sb_empty", sb.size(), 32'd0);

        // Extended key: E0F0 must not produce an event
        do_reset();
        ev_ready = 1'b1;
        sb.push_back(11'h375);
        sb.push_back(11'h075);
        cyc(16'hE075, 1);
        cyc(16'hE0F0, 1);
        cyc(16'hF075, 1);
        cyc(16'h1FFF, 3);
        check("ext_last_make", {24'd0, last_make}, 32'h75);
        check("ext_sb_empty", sb.size(), 32'd0);

        // Fill and overflow: ninth make (scan 18) is dropped
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) sb.push_back(11'h210 + 11'(i));
            cyc(16'h0010 + 16'(i), 1);
        end
        check("fill_count", {28'd0, count}, 32'd8);
        check("fill_overflow", {31'd0, overflow}, 32'd1);
        ev_ready = 1'b1;
        cyc(16'h1FFF, 10);
        check("drain_count", {28'd0, count}, 32'd0);
        check("drain_overflow_sticky", {31'd0, overflow}, 32'd1);
        check("drain_sb_empty", sb.size(), 32'd0);
        ovf_clr = 1'b1;
        cyc(16'h1FFF, 1);
        ovf_clr = 1'b0;
        check("ovf_clr", {31'd0, overflow}, 32'd0);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            sb.push_back(11'h220 + 11'(i));
            cyc(16'h0020 + 16'(i), 1);
        end
        check("full_count", {28'd0, count}, 32'd8);
        sb.push_back(11'h228);
        ev_ready = 1'b1;
        cyc(16'h0028, 1);
        ev_ready = 1'b0;
        check("pushpop_count", {28'd0, count}, 32'd8);
        check("pushpop_overflow", {31'd0, overflow}, 32'd0);
        cyc(16'h1FFF, 2);
        check("pushpop_head_stable", {21'd0, ev_data}, 32'h221);
        ev_ready = 1'b1;
        cyc(16'h1FFF, 10);
        check("pushpop_sb_empty", sb.size(), 32'd0);

        // Reset mid-stream with three events queued
        do_reset();
        cyc(16'h0030, 1);
        cyc(16'h0031, 1);
        cyc(16'h0032, 1);
        check("mid_count", {28'd0, count}, 32'd3);
        rst_n = 1'b0;
        cyc(16'h0029, 1);
        check_reset_outputs("midrst");
        sb.delete();
        rst_n = 1'b1;
        ev_ready = 1'b1;
        sb.push_back(11'h229);
        cyc(16'h0029, 4);
        check("midrst_last_make", {24'd0, last_make}, 32'h29);
        check("midrst_count", {28'd0, count}, 32'd0);
        check("midrst_sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_fifo.md
# ps2_key_event_fifo

Downstream consumer of the PS/2 receiver's 16-bit `code` bus. Watches the bus every clock, discards the receiver's idle and status patterns, and turns each genuine key code into a typed key event: make or break, extended flag, typematic-repeat flag and scan code. Events are queued in a small FIFO and handed to the application layer (display or ASCII mapper) over a valid/ready handshake.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `AW`, 3: pointer width; equals log2(`DEPTH`).

- `clk`  in  1: system clock. This is the same clock as the receiver.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `code`  in  16: receiver code bus.
- `ev_ready`  in  1: consumer accepts the head event.
- `ovf_clr`  in  1: single-cycle pulse that clears `overflow`.
- `ev_valid`  out  1: the head event is valid.
- `ev_data`  out  11: the head event, packed as {repeat, make, ext, scan[7:0]}.
- `count`  out  AW+1: FIFO occupancy, 0..DEPTH.
- `overflow`  out  1: sticky flag; set when an event is dropped.
- `last_make`  out  8: scan code of the most recent make event.

## Operation
- **Input register.** `code` is registered every cycle into `code_q`. `code_q` resets to 16'hFFFF.
- **Classification.** Classification uses the upper byte `hi` and lower byte `lo` of `code`.
  - `hi` = 8'h00 or 8'h11: make, ext=0, scan=`lo`.
  - `hi` = 8'hE0 and `lo` ≠ 8'hF0: make, ext=1, scan=`lo`.
  - `hi` = 8'hF0: break, ext=0, scan=`lo`.
  - Everything else is ignored. This covers 16'hFFFF, 16'h5555, every status pattern with `lo` = 8'hFF, and 16'hE0F0.
- **Detection.** An event is detected in a cycle when `code` is classified as valid and `code` ≠ `code_q`. A code held stable on the bus generates exactly one event.
- **Repeat flag.**
  - `repeat` = 1 when the event is a make with the same ext and scan as the last make event, and no break has occurred since that make.
  - Otherwise `repeat` = 0.
  - Any break event clears the "last make valid" state.
- **`last_make` update.** `last_make` is updated on every detected make event, including repeats. It resets to 8'h00.
- **FIFO.** The FIFO is a circular buffer with `DEPTH` entries.
  - Write and read pointers are `AW` bits wide and wrap from DEPTH-1 to 0.
  - `count` is maintained separately.
  - Full when `count` == DEPTH. Empty when `count` == 0.
- **Push.** A detected event is pushed in the same cycle it is detected, i.e. it is written on the clock edge that also updates `code_q`.
- **Pop.** A pop occurs when `ev_valid` && `ev_ready`.
- **Push and pop together.**
  - Not full: both happen and `count` is unchanged.
  - Full: both happen, the event is stored and `overflow` is not set.
- **Push while full, no pop.** The new event is dropped. FIFO contents are unchanged and `overflow` is set.
- **`overflow`.** Cleared by `ovf_clr` or reset. If a set condition and `ovf_clr` occur in the same cycle, set wins.
- **Outputs.** `ev_valid` = (`count` ≠ 0). `ev_data` is the entry at the read pointer; it is registered from storage and is stable while `ev_valid` && !`ev_ready`.

## Timing
- **Reset values.** `ev_valid`=0, `ev_data`=11'h000, `count`=0, `overflow`=0, `last_make`=8'h00. Pointers are 0, `code_q`=16'hFFFF and "last make valid" is 0.
- **Reset mid-operation.** Queued events are discarded. The first valid code seen after reset release is detected as an event, because `code_q` starts at 16'hFFFF.
- **Latency.** If `code` changes to a valid value before edge N, then `ev_valid` is 1 and `ev_data` shows the event after edge N, provided the FIFO was empty.
- **Throughput.** One push and one pop per cycle maximum.
- **Handshake.** `ev_data` may only change after a pop or when going from empty to non-empty. `ev_valid` never drops without a pop, except on reset.
- **Back-to-back codes.** Codes that change on consecutive cycles each produce an event, and each must be valid at a sampling edge.

## Test plan
- **Make.** After reset, drive `code`=16'h001C for 3 cycles, then 16'h1FFF, with `ev_ready`=1. Expect exactly one event, `ev_data`=11'h21C (make, not repeat), then `ev_valid`=0. `last_make` becomes 8'h1C.
- **Typematic repeat.** Drive 16'h001C, 16'h3FFF, 16'h001C, 16'h5555, then 16'hF01C. Expect events 11'h21C, 11'h61C (repeat), 11'h01C (break). A following 16'h001C yields 11'h21C again.
- **Extended key.** Drive 16'hE075, 16'hE0F0, then 16'hF075. Expect 11'h375, nothing for E0F0, then 11'h075.
- **Fill and overflow.** With `ev_ready`=0, push 9 distinct makes (scan 8'h10..8'h18). Expect `count`=8 and `overflow`=1. Draining yields scans 10..17 in order and 8'h18 is lost. An `ovf_clr` pulse then gives `overflow`=0.
- **Full with simultaneous push and pop.** With the FIFO full and `ev_ready`=1 for one cycle while a new code arrives: `count` stays 8, `overflow` stays 0, and the new event appears last.
- **Reset mid-stream.** With 3 events queued, hold `rst_n`=0 for one edge while `code`=16'h0029. Expect all outputs at reset values. After release, expect one event 11'h229.
